// File: rtl/uart_rx.sv
// uart_rx: 8E1 serial receiver (start, 8 data LSB first, even parity, stop).
// Bytes are offered on a valid/ready output. Error events are reported as
// one-cycle pulses.
// Build option: define UART_RX_FIFO_EN to place a 4-entry FIFO between the
// deserializer and the outputs. Without it, a single holding register is used.
package riscv_pkg;
  localparam int unsigned UART_BAUDRATE = 115_200;
endpackage

module uart_rx #(
  parameter int unsigned CLK_FREQ_HZ = 70_000_000,
  parameter int unsigned BAUDRATE    = riscv_pkg::UART_BAUDRATE
) (
  input  logic       sys_clk,
  input  logic       sys_rstn,
  input  logic       rx_i,
  output logic [7:0] m_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overrun
);

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned BIT_CYC = (CLK_FREQ_HZ + BAUDRATE / 2) / BAUDRATE;
  localparam int unsigned CNT_W   = $clog2(BIT_CYC) + 1;
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(BIT_CYC - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BIT_CYC / 2 - 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP, WAIT_IDLE
  } state_t;

  logic              sync_q1;
  logic              rx_s;
  logic              rx_prev;
  logic [1:0]        settle;
  logic              fall;
  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        bit_idx;
  logic [DATA_W-1:0] shreg;
  logic              par_bad;
  logic              push;
  logic              bit_done;

  // Two-flop synchronizer plus edge-detect history. The settle counter keeps
  // the edge detector blind until the chain holds real line samples, so a line
  // that is already low at reset release is never mistaken for a start edge.
  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      sync_q1 <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
      settle  <= 2'd0;
    end else begin
      sync_q1 <= rx_i;
      rx_s    <= sync_q1;
      rx_prev <= rx_s;
      if (settle != 2'd3) settle <= settle + 2'd1;
    end
  end

  assign fall     = (settle == 2'd3) && rx_prev && !rx_s;
  assign bit_done = (cnt == FULL_LAST);

  // Frame sequencer: bit timing, sampling and registered error/push pulses.
  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      par_bad    <= 1'b0;
      push       <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      push       <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (fall) state <= START;
        end
        START: begin
          if (cnt == HALF_LAST) begin
            cnt     <= '0;
            bit_idx <= '0;
            // A high line at mid start bit is a glitch: drop it silently.
            state   <= rx_s ? IDLE : DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_done) begin
            cnt     <= '0;
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= PARITY;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PARITY: begin
          if (bit_done) begin
            cnt     <= '0;
            par_bad <= (rx_s != (^shreg));
            state   <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (bit_done) begin
            cnt <= '0;
            if (!rx_s) begin
              // Framing error wins over parity; wait for the line to recover.
              frame_err <= 1'b1;
              state     <= WAIT_IDLE;
            end else if (par_bad) begin
              parity_err <= 1'b1;
              state      <= IDLE;
            end else begin
              push  <= 1'b1;
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_IDLE: begin
          cnt <= '0;
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Data shift register (LSB first); pure datapath, no reset needed.
  always_ff @(posedge sys_clk) begin
    if (state == DATA && bit_done) shreg <= {rx_s, shreg[DATA_W-1:1]};
  end

`ifdef UART_RX_FIFO_EN
  logic [DATA_W-1:0] mem [4];
  logic [1:0]        wr_ptr;
  logic [1:0]        rd_ptr;
  logic [2:0]        count;
  logic              pop;
  logic              full;
  logic              wr_en;

  assign m_valid = (count != 3'd0);
  assign m_data  = mem[rd_ptr];
  assign pop     = m_valid && m_ready;
  assign full    = (count == 3'd4);
  // A simultaneous pop frees the slot the push needs, even when full.
  assign wr_en   = push && (!full || pop);

  // Four-entry output FIFO with overrun pulse when a push finds no room.
  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      for (int i = 0; i < 4; i++) mem[i] <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      overrun <= push && !wr_en;
      if (wr_en) begin
        mem[wr_ptr] <= shreg;
        wr_ptr      <= wr_ptr + 2'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 2'd1;
      case ({wr_en, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end
`else
  // Single holding register; a push while the old byte is still pending
  // is dropped and flagged, leaving the held byte untouched.
  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      m_data  <= '0;
      m_valid <= 1'b0;
      overrun <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (push) begin
        if (!m_valid || m_ready) begin
          m_data  <= shreg;
          m_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (m_valid && m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed and randomized frames against a frame-level model of
// the receiver (byte delivered, parity error or framing error per frame).
module tb_uart_rx;

  localparam int CLK_HZ = 3_200_000;
  localparam int BAUD   = 100_000;
  localparam int BIT    = 32;
`ifdef UART_RX_FIFO_EN
  localparam int CAP = 4;
`else
  localparam int CAP = 1;
`endif

  logic       sys_clk  = 1'b0;
  logic       sys_rstn = 1'b0;
  logic       rx_i     = 1'b1;
  logic       m_ready  = 1'b1;
  logic [7:0] m_data;
  logic       m_valid;
  logic       parity_err;
  logic       frame_err;
  logic       overrun;

  int n_checks = 0;
  int n_fail   = 0;

  uart_rx #(.CLK_FREQ_HZ(CLK_HZ), .BAUDRATE(BAUD)) dut (
    .sys_clk    (sys_clk),
    .sys_rstn   (sys_rstn),
    .rx_i       (rx_i),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overrun    (overrun)
  );

  always #5 sys_clk = ~sys_clk;

  // Output monitor: log accepted bytes and count pulse/valid cycles.
  logic [7:0] rx_log [0:255];
  int rx_n = 0, pe_n = 0, fe_n = 0, ov_n = 0, vld_n = 0;
  always @(negedge sys_clk) begin
    if (m_valid && m_ready) begin
      rx_log[rx_n[7:0]] <= m_data;
      rx_n <= rx_n + 1;
    end
    if (m_valid)    vld_n <= vld_n + 1;
    if (parity_err) pe_n  <= pe_n + 1;
    if (frame_err)  fe_n  <= fe_n + 1;
    if (overrun)    ov_n  <= ov_n + 1;
  end

  int b_rx, b_pe, b_fe, b_ov, b_vld;

  task automatic snap();
    b_rx = rx_n; b_pe = pe_n; b_fe = fe_n; b_ov = ov_n; b_vld = vld_n;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    rx_i = b;
    tick(BIT);
  endtask

  // One 8E1 frame; par_flip corrupts parity, stop_bit=0 plus low_bits extra
  // low bit times produces a framing error. Ends with two idle bit times.
  task automatic send_frame(input logic [7:0] d, input logic par_flip,
                            input logic stop_bit, input int low_bits);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit((^d) ^ par_flip);
    send_bit(stop_bit);
    if (!stop_bit) repeat (low_bits) send_bit(1'b0);
    rx_i = 1'b1;
    tick(2 * BIT);
  endtask

  logic [7:0] d;
  int kind;
  int exp_rx, exp_pe, exp_fe, exp_ov;

  initial begin
    // Reset state
    tick(3);
    check("rst_valid", m_valid, 0);
    check("rst_data", m_data, 8'h00);
    check("rst_perr", parity_err, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_ovr", overrun, 0);
    sys_rstn = 1'b1;
    tick(5);

    // Clean byte, consumer always ready
    snap();
    send_frame(8'hA5, 1'b0, 1'b1, 0);
    check("a5_count", rx_n - b_rx, 1);
    check("a5_data", rx_log[rx_n[7:0] - 8'd1], 8'hA5);
    check("a5_vld_cycles", vld_n - b_vld, 1);
    check("a5_perr", pe_n - b_pe, 0);
    check("a5_ferr", fe_n - b_fe, 0);
    check("a5_ovr", ov_n - b_ov, 0);

    // Wrong parity on 8'h01 (parity bit sent as 0)
    snap();
    send_frame(8'h01, 1'b1, 1'b1, 0);
    check("par_perr", pe_n - b_pe, 1);
    check("par_vld", vld_n - b_vld, 0);
    check("par_ferr", fe_n - b_fe, 0);

    // Stop bit low, line held low for three bit times, then a good byte
    snap();
    send_frame(8'h3C, 1'b0, 1'b0, 2);
    check("frm_ferr", fe_n - b_fe, 1);
    check("frm_perr", pe_n - b_pe, 0);
    check("frm_count", rx_n - b_rx, 0);
    snap();
    send_frame(8'h55, 1'b0, 1'b1, 0);
    check("after_frm_count", rx_n - b_rx, 1);
    check("after_frm_data", rx_log[rx_n[7:0] - 8'd1], 8'h55);

    // Short low glitch on an idle line is ignored
    snap();
    rx_i = 1'b0;
    tick(10);
    rx_i = 1'b1;
    tick(3 * BIT);
    check("glitch_vld", vld_n - b_vld, 0);
    check("glitch_perr", pe_n - b_pe, 0);
    check("glitch_ferr", fe_n - b_fe, 0);
    snap();
    send_frame(8'hC3, 1'b0, 1'b1, 0);
    check("after_glitch_count", rx_n - b_rx, 1);
    check("after_glitch_data", rx_log[rx_n[7:0] - 8'd1], 8'hC3);

    // Consumer stalled: one more byte than storage can hold
    m_ready = 1'b0;
    snap();
    for (int k = 0; k <= CAP; k++) send_frame(8'((k + 1) * 8'h11), 1'b0, 1'b1, 0);
    check("ovr_pulses", ov_n - b_ov, 1);
    check("ovr_valid", m_valid, 1);
    check("ovr_head", m_data, 8'h11);
    m_ready = 1'b1;
    tick(10);
    check("drain_count", rx_n - b_rx, CAP);
    for (int k = 0; k < CAP; k++)
      check("drain_data", rx_log[8'(b_rx + k)], 8'((k + 1) * 8'h11));
    check("drain_valid", m_valid, 0);

    // Randomized frames against the frame-level model
    snap();
    exp_rx = b_rx; exp_pe = b_pe; exp_fe = b_fe; exp_ov = b_ov;
    for (int f = 0; f < 24; f++) begin
      d    = 8'($urandom);
      kind = int'($urandom_range(0, 3));
      send_frame(d, kind == 2, kind != 3, 1);
      if (kind == 3)      exp_fe++;
      else if (kind == 2) exp_pe++;
      else                exp_rx++;
      check("rnd_count", rx_n, exp_rx);
      check("rnd_perr", pe_n, exp_pe);
      check("rnd_ferr", fe_n, exp_fe);
      check("rnd_ovr", ov_n, exp_ov);
      if (kind < 2) check("rnd_data", rx_log[rx_n[7:0] - 8'd1], d);
    end

    // Reset in the middle of a frame while a byte is held
    m_ready = 1'b0;
    send_frame(8'h5A, 1'b0, 1'b1, 0);
    check("hold_valid", m_valid, 1);
    check("hold_data", m_data, 8'h5A);
    snap();
    send_bit(1'b0);
    repeat (4) send_bit(1'b0);
    rx_i = 1'b0;
    tick(BIT / 2);
    sys_rstn = 1'b0;
    #2;
    check("mid_rst_valid", m_valid, 0);
    check("mid_rst_data", m_data, 8'h00);
    check("mid_rst_perr", parity_err, 0);
    check("mid_rst_ferr", frame_err, 0);
    check("mid_rst_ovr", overrun, 0);
    tick(3);
    sys_rstn = 1'b1;
    m_ready  = 1'b1;
    tick(BIT / 2);
    repeat (3) send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    tick(2 * BIT);
    check("aborted_count", rx_n - b_rx, 0);
    check("aborted_perr", pe_n - b_pe, 0);
    check("aborted_ferr", fe_n - b_fe, 0);
    snap();
    send_frame(8'hF0, 1'b0, 1'b1, 0);
    check("f0_count", rx_n - b_rx, 1);
    check("f0_data", rx_log[rx_n[7:0] - 8'd1], 8'hF0);
    check("f0_flags", (pe_n - b_pe) + (fe_n - b_fe) + (ov_n - b_ov), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLK_FREQ_HZ, default 70_000_000, sys_clk frequency in Hz.
REQ-002 Parameter BAUDRATE, default riscv_pkg::UART_BAUDRATE, line bit rate.
REQ-003 sys_clk  in  1  single clock; all logic on rising edge.
REQ-004 sys_rstn  in  1  reset, asynchronous assert, active-low.
REQ-005 rx_i  in  1  serial line from top-level uart_txd_in, asynchronous to sys_clk, idle high.
REQ-006 m_data  out  8  received byte.
REQ-007 m_valid  out  1  m_data holds an unconsumed byte.
REQ-008 m_ready  in  1  consumer accepts byte when m_valid && m_ready.
REQ-009 parity_err  out  1  one-cycle pulse: parity mismatch.
REQ-010 frame_err  out  1  one-cycle pulse: stop bit sampled low.
REQ-011 overrun  out  1  one-cycle pulse: completed byte dropped for lack of space.

Function
REQ-012 Frame: 1 start (0), 8 data LSB first, 1 even-parity bit (equals XOR of the 8 data bits), 1 stop (1).
REQ-013 rx_i passes through a 2-flop synchronizer (flops reset to 1) before any use.
REQ-014 BIT_CYC = round(CLK_FREQ_HZ/BAUDRATE) (608 at defaults); counter width = $clog2(BIT_CYC)+1.
REQ-015 FSM states IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
REQ-016 IDLE: synchronized falling edge -> START, counter cleared.
REQ-017 START: sample at BIT_CYC/2; 0 -> DATA; 1 -> IDLE (glitch rejected, no flag).
REQ-018 DATA: sample every BIT_CYC into shift register; after 8th sample -> PARITY.
REQ-019 PARITY: sample after BIT_CYC; store mismatch flag -> STOP.
REQ-020 STOP: sample after BIT_CYC; 1 and parity ok -> push byte, IDLE; 1 and parity bad -> parity_err pulse, byte discarded, IDLE; 0 -> frame_err pulse (takes priority, parity_err not raised), byte discarded, WAIT_IDLE.
REQ-021 WAIT_IDLE: stay until synchronized line is 1, then IDLE.
REQ-022 Push occurs the cycle after the stop-bit sample; m_valid rises the following cycle (latency 2 cycles from stop sample).
REQ-023 m_valid stays high and m_data stable until handshake; m_valid && m_ready in the same cycle as a push keeps m_valid high with new data.
REQ-024 Push with no free space: byte dropped, overrun pulses, stored data untouched.

Reset
REQ-025 sys_rstn low: FSM -> IDLE, counters 0, synchronizer 1, m_data 8'h00, m_valid 0, parity_err 0, frame_err 0, overrun 0, storage emptied.
REQ-026 Reset mid-frame aborts frame; after release a new frame is accepted only after a fresh falling edge.

Configuration
REQ-027 Macro UART_RX_FIFO_EN defined: 4-entry FIFO between deserializer and outputs; m_valid = not empty; overrun only when full; push and pop in same cycle while full both succeed.
REQ-028 Macro UART_RX_FIFO_EN undefined: single holding register; overrun when m_valid && !m_ready at push.

Verification
REQ-029 Send 8'hA5 with parity 0, stop 1, m_ready=1 -> m_data=8'hA5, m_valid one cycle, no error pulses.
REQ-030 Send 8'h01 with parity 0 (wrong) -> parity_err one pulse, m_valid stays 0.
REQ-031 Send 8'h3C with stop bit 0, line held low 3 bit times -> frame_err one pulse, no byte, next 8'h55 received correctly.
REQ-032 Low glitch of 200 cycles on idle line -> no m_valid, no flags, FSM back in IDLE.
REQ-033 m_ready=0, send 8'h11, 8'h22 -> no FIFO: m_data=8'h11, overrun once; FIFO: both delivered in order, overrun only on 5th byte.
REQ-034 Assert sys_rstn low during bit 4 of a frame -> all outputs reset values; next frame 8'hF0 received correctly.
